fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the opcode decoder.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched 16-bit word and PC+1 for decode; opcode is inst[15:12], and PC+1 is the JAL link value.
- Applies stall from the hazard unit and redirects from jump (ID), branch and jr (EX), and inserts bubbles on redirect.

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_stage_pc_reg.sv | 62 ++++++
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared widths, bubble word and opcode-field helpers for the fetch stage
// and the decoder that consumes its IF/ID register.
package fetch_stage_pkg;

  localparam int PC_W   = 8;
  localparam int INST_W = 16;
  localparam int CNT_W  = 16;

  // Opcode field position within an instruction word.
  localparam int OPC_MSB = INST_W - 1;
  localparam int OPC_LSB = INST_W - 4;

  // Opcode 4'hF is reserved; the decoder maps it to the all-zero control word.
  localparam logic [3:0]        OP_RSVD  = 4'hF;
  localparam logic [INST_W-1:0] NOP_INST = {OP_RSVD, {(INST_W-4){1'b0}}};

  typedef enum logic [1:0] {
    SEL_ADV,
    SEL_HOLD,
    SEL_REDIR
  } pc_sel_e;

  function automatic logic [3:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with redirect target selection, stall hold and increment.
// EX redirects (branch, then jr) outrank the ID jump.
module fetch_stage_pc_reg #(
  parameter int          PC_W     = fetch_stage_pkg::PC_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            jr_taken_i,
  input  logic [PC_W-1:0] jr_target_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_inc_o,
  output logic            redirect_o,
  output logic            hold_o
);
  import fetch_stage_pkg::*;

  pc_sel_e         sel;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  always_comb begin
    sel    = SEL_ADV;
    target = jump_target_i;
    pc_d   = pc_q;
    if (branch_taken_i) begin
      target = branch_target_i;
    end else if (jr_taken_i) begin
      target = jr_target_i;
    end
    if (branch_taken_i || jr_taken_i || jump_i) begin
      sel = SEL_REDIR;
    end else if (stall_i) begin
      sel = SEL_HOLD;
    end
    case (sel)
      SEL_REDIR: pc_d = target;
      SEL_HOLD:  pc_d = pc_q;
      default:   pc_d = pc_q + 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_inc_o   = pc_q + 1'b1;
  assign redirect_o = (sel == SEL_REDIR);
  assign hold_o     = (sel == SEL_HOLD);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID pipeline register and saturating fetch counter.
// A redirect loads a bubble into IF/ID; a stall freezes everything.
module fetch_stage #(
  parameter int                PC_W     = fetch_stage_pkg::PC_W,
  parameter int                INST_W   = fetch_stage_pkg::INST_W,
  parameter int unsigned       RESET_PC = 0,
  parameter logic [INST_W-1:0] NOP_INST = fetch_stage_pkg::NOP_INST,
  parameter int                CNT_W    = fetch_stage_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              jr_taken,
  input  logic [PC_W-1:0]   jr_target,
  input  logic              jump,
  input  logic [PC_W-1:0]   jump_target,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] if_id_inst,
  output logic [PC_W-1:0]   if_id_pc1,
  output logic              if_id_valid,
  output logic [CNT_W-1:0]  fetch_count
);

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_inc;
  logic              redirect;
  logic              hold;

  logic [INST_W-1:0] inst_d, inst_q;
  logic [PC_W-1:0]   pc1_d, pc1_q;
  logic              valid_d, valid_q;
  logic [CNT_W-1:0]  count_d, count_q;

  fetch_stage_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jr_taken_i      (jr_taken),
    .jr_target_i     (jr_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .pc_o            (pc),
    .pc_inc_o        (pc_inc),
    .redirect_o      (redirect),
    .hold_o          (hold)
  );

  always_comb begin
    inst_d  = inst_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    count_d = count_q;
    if (redirect) begin
      inst_d  = NOP_INST;
      pc1_d   = '0;
      valid_d = 1'b0;
    end else if (!hold) begin
      inst_d  = imem_rdata;
      pc1_d   = pc_inc;
      valid_d = 1'b1;
      // Saturate rather than wrap so the count stays meaningful on long runs.
      if (!(&count_q)) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc1_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      inst_q  <= inst_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc;
  assign if_id_inst  = inst_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem returns 16'h1000 + address; a second
// instance with a 2-bit counter checks saturation.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        jr_taken;
  logic [7:0]  jr_target;
  logic        jump;
  logic [7:0]  jump_target;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] if_id_inst;
  logic [7:0]  if_id_pc1;
  logic        if_id_valid;
  logic [15:0] fetch_count;

  logic [7:0]  s_imem_addr;
  logic [15:0] s_imem_rdata;
  logic [15:0] s_if_id_inst;
  logic [7:0]  s_if_id_pc1;
  logic        s_if_id_valid;
  logic [1:0]  s_fetch_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_rdata   = 16'h1000 + {8'h00, imem_addr};
  assign s_imem_rdata = 16'h1000 + {8'h00, s_imem_addr};

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jr_taken      (jr_taken),
    .jr_target     (jr_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_inst    (if_id_inst),
    .if_id_pc1     (if_id_pc1),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count)
  );

  fetch_stage #(.CNT_W(2)) dut_small (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jr_taken      (jr_taken),
    .jr_target     (jr_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (s_imem_addr),
    .imem_rdata    (s_imem_rdata),
    .if_id_inst    (s_if_id_inst),
    .if_id_pc1     (s_if_id_pc1),
    .if_id_valid   (s_if_id_valid),
    .fetch_count   (s_fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] pc, input logic [15:0] inst,
                           input logic [7:0] pc1, input logic valid, input logic [15:0] cnt);
    check({tag, ".pc"},    32'(imem_addr),   32'(pc));
    check({tag, ".inst"},  32'(if_id_inst),  32'(inst));
    check({tag, ".pc1"},   32'(if_id_pc1),   32'(pc1));
    check({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
    check({tag, ".count"}, 32'(fetch_count), 32'(cnt));
    $display("[%0t] %s pc=%02h inst=%04h pc1=%02h valid=%0b count=%0d small_count=%0d",
             $time, tag, imem_addr, if_id_inst, if_id_pc1, if_id_valid, fetch_count, s_fetch_count);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00;
    jr_taken = 1'b0; jr_target = 8'h00;
    jump = 1'b0; jump_target = 8'h00;

    repeat (2) @(negedge clk);
    check_all("reset", 8'h00, 16'hF000, 8'h00, 1'b0, 16'd0);
    check("reset.small_count", 32'(s_fetch_count), 32'd0);
    rst = 1'b0;

    step(); check_all("seq0", 8'h01, 16'h1000, 8'h01, 1'b1, 16'd1);
    check("seq0.small_count", 32'(s_fetch_count), 32'd1);
    step(); check_all("seq1", 8'h02, 16'h1001, 8'h02, 1'b1, 16'd2);
    check("seq1.small_count", 32'(s_fetch_count), 32'd2);
    step(); check_all("seq2", 8'h03, 16'h1002, 8'h03, 1'b1, 16'd3);
    check("seq2.small_count", 32'(s_fetch_count), 32'd3);
    step(); step(); check_all("adv5", 8'h05, 16'h1004, 8'h05, 1'b1, 16'd5);
    check("sat.small_count", 32'(s_fetch_count), 32'd3);

    stall = 1'b1;
    step(); check_all("stall1", 8'h05, 16'h1004, 8'h05, 1'b1, 16'd5);
    step(); check_all("stall2", 8'h05, 16'h1004, 8'h05, 1'b1, 16'd5);
    stall = 1'b0;
    step(); check_all("unstall", 8'h06, 16'h1005, 8'h06, 1'b1, 16'd6);
    step(); check_all("adv7", 8'h07, 16'h1006, 8'h07, 1'b1, 16'd7);

    jump = 1'b1; jump_target = 8'h40;
    step(); check_all("jump", 8'h40, 16'hF000, 8'h00, 1'b0, 16'd7);
    jump = 1'b0;
    step(); check_all("after_jump", 8'h41, 16'h1040, 8'h41, 1'b1, 16'd8);

    branch_taken = 1'b1; branch_target = 8'h20;
    jr_taken = 1'b1; jr_target = 8'h30;
    jump = 1'b1; jump_target = 8'h40; stall = 1'b1;
    step(); check_all("redir_all", 8'h20, 16'hF000, 8'h00, 1'b0, 16'd8);
    branch_taken = 1'b0; stall = 1'b0;
    step(); check_all("redir_jr", 8'h30, 16'hF000, 8'h00, 1'b0, 16'd8);
    jr_taken = 1'b0; jump = 1'b0;
    step(); check_all("after_jr", 8'h31, 16'h1030, 8'h31, 1'b1, 16'd9);

    jump = 1'b1; jump_target = 8'hFF;
    step(); check_all("to_ff", 8'hFF, 16'hF000, 8'h00, 1'b0, 16'd9);
    jump = 1'b0;
    step(); check_all("wrap", 8'h00, 16'h10FF, 8'h00, 1'b1, 16'd10);
    step(); check_all("post_wrap", 8'h01, 16'h1000, 8'h01, 1'b1, 16'd11);
    check("post_wrap.small_count", 32'(s_fetch_count), 32'd3);

    stall = 1'b1;
    step(); check_all("pre_rst", 8'h01, 16'h1000, 8'h01, 1'b1, 16'd11);
    #2 rst = 1'b1;
    #1 check_all("async_rst", 8'h00, 16'hF000, 8'h00, 1'b0, 16'd0);
    check("async_rst.small_count", 32'(s_fetch_count), 32'd0);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    step(); check_all("rst_refetch", 8'h01, 16'h1000, 8'h01, 1'b1, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
